// File: rtl/rename_nwide_if.sv
// Handshake and data bundle between decode FIFO / free list and the N-wide rename stage.
// The slave modport is the rename stage's view; the master modport is the surrounding pipeline.
interface rename_nwide_if #(
  parameter int WIDTH    = 2,
  parameter int NUM_ARCH = 32,
  parameter int LOG_ARCH = 5,
  parameter int LOG_PHYS = 6,
  parameter int CW       = 2
);
  logic [WIDTH-1:0]          in_valid;
  logic [WIDTH*LOG_ARCH-1:0] in_src_a;
  logic [WIDTH*LOG_ARCH-1:0] in_src_b;
  logic [WIDTH*LOG_ARCH-1:0] in_dst;
  logic [WIDTH-1:0]          in_reg_write;
  logic [CW-1:0]             in_take;
  logic [LOG_PHYS:0]         free_count;
  logic [WIDTH*LOG_PHYS-1:0] free_regs;
  logic [CW-1:0]             alloc_count;
  logic [CW-1:0]             rob_space;
  logic [CW-1:0]             iq_space;
  logic                      wb_valid;
  logic [LOG_PHYS-1:0]       wb_preg;
  logic                      flush;
  logic [NUM_ARCH*LOG_PHYS-1:0] restore_map;
  logic [WIDTH-1:0]          out_valid;
  logic                      out_ready;
  logic [WIDTH*LOG_PHYS-1:0] out_psrc_a;
  logic [WIDTH*LOG_PHYS-1:0] out_psrc_b;
  logic [WIDTH-1:0]          out_rdy_a;
  logic [WIDTH-1:0]          out_rdy_b;
  logic [WIDTH*LOG_PHYS-1:0] out_pdst;
  logic [WIDTH*LOG_PHYS-1:0] out_old_pdst;

  modport slave (
    input  in_valid, in_src_a, in_src_b, in_dst, in_reg_write, free_count, free_regs,
           rob_space, iq_space, wb_valid, wb_preg, flush, restore_map, out_ready,
    output in_take, alloc_count, out_valid, out_psrc_a, out_psrc_b, out_rdy_a, out_rdy_b,
           out_pdst, out_old_pdst
  );

  modport master (
    output in_valid, in_src_a, in_src_b, in_dst, in_reg_write, free_count, free_regs,
           rob_space, iq_space, wb_valid, wb_preg, flush, restore_map, out_ready,
    input  in_take, alloc_count, out_valid, out_psrc_a, out_psrc_b, out_rdy_a, out_rdy_b,
           out_pdst, out_old_pdst
  );
endinterface

// File: rtl/rename_nwide.sv
// N-wide register rename: speculative F-RAT, physical busy table, in-group dependency
// resolution and a single registered output stage with valid/ready handshake.
module rename_nwide #(
  parameter int WIDTH    = 2,
  parameter int NUM_ARCH = 32,
  parameter int LOG_ARCH = 5,
  parameter int NUM_PHYS = 64,
  parameter int LOG_PHYS = 6,
  parameter int CW       = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  rename_nwide_if.slave bus
);
  logic [LOG_PHYS-1:0]       map_q [NUM_ARCH];
  logic [LOG_PHYS-1:0]       map_d [NUM_ARCH];
  logic [NUM_PHYS-1:0]       busy_q, busy_d;
  logic [WIDTH-1:0]          out_valid_q, out_valid_d;
  logic [WIDTH-1:0]          rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
  logic [WIDTH*LOG_PHYS-1:0] psrc_a_q, psrc_a_d, psrc_b_q, psrc_b_d;
  logic [WIDTH*LOG_PHYS-1:0] pdst_q, pdst_d, old_q, old_d;
  logic [WIDTH*LOG_PHYS-1:0] ren_psrc_a_s, ren_psrc_b_s, ren_pdst_s, ren_old_s;
  logic [WIDTH-1:0]          ren_rdy_a_s, ren_rdy_b_s;
  logic [WIDTH-1:0]          alloc_s;
  logic [LOG_PHYS-1:0]       new_pdst_s [WIDTH];
  logic                      can_load_s;
  int                        k_s, nalloc_s;

  function automatic logic [LOG_ARCH-1:0] arch_at(input logic [WIDTH*LOG_ARCH-1:0] v, input int j);
    return v[j*LOG_ARCH +: LOG_ARCH];
  endfunction

  // Youngest earlier in-group writer of the same arch reg overrides the F-RAT (returns {preg, rdy}).
  function automatic logic [LOG_PHYS:0] src_lookup(input logic [LOG_ARCH-1:0] s, input int j);
    logic [LOG_PHYS-1:0] p;
    logic                r;
    p = map_q[s];
    r = !busy_q[p] || (bus.wb_valid && (bus.wb_preg == p));
    for (int i = 0; i < j; i++) begin
      if (alloc_s[i] && (arch_at(bus.in_dst, i) == s)) begin
        p = new_pdst_s[i];
        r = 1'b0;
      end
    end
    if (s == '0) begin
      p = '0;
      r = 1'b1;
    end
    return {p, r};
  endfunction

  function automatic logic [LOG_PHYS-1:0] old_lookup(input logic [LOG_ARCH-1:0] d, input int j);
    logic [LOG_PHYS-1:0] p;
    p = map_q[d];
    for (int i = 0; i < j; i++) begin
      if (alloc_s[i] && (arch_at(bus.in_dst, i) == d)) p = new_pdst_s[i];
    end
    return p;
  endfunction

  always_comb begin
    int n;
    n = 0;
    for (int j = 0; j < WIDTH; j++) begin
      alloc_s[j] = bus.in_reg_write[j] && (arch_at(bus.in_dst, j) != '0);
      if (alloc_s[j]) begin
        new_pdst_s[j] = bus.free_regs[n*LOG_PHYS +: LOG_PHYS];
        n = n + 1;
      end else begin
        new_pdst_s[j] = '0;
      end
    end
  end

  // Largest acceptable prefix: stops at the first slot that is invalid or lacks any resource.
  always_comb begin
    logic stop;
    can_load_s = (out_valid_q == '0) || bus.out_ready;
    k_s        = 0;
    nalloc_s   = 0;
    stop       = rst_i || bus.flush || !can_load_s;
    for (int j = 0; j < WIDTH; j++) begin
      if (!stop && bus.in_valid[j] && (j + 1 <= int'(bus.rob_space)) &&
          (j + 1 <= int'(bus.iq_space)) &&
          (nalloc_s + int'(alloc_s[j]) <= int'(bus.free_count))) begin
        k_s      = j + 1;
        nalloc_s = nalloc_s + int'(alloc_s[j]);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    logic [LOG_PHYS:0] la, lb;
    ren_psrc_a_s = '0;
    ren_psrc_b_s = '0;
    ren_rdy_a_s  = '0;
    ren_rdy_b_s  = '0;
    ren_pdst_s   = '0;
    ren_old_s    = '0;
    for (int j = 0; j < WIDTH; j++) begin
      la = src_lookup(arch_at(bus.in_src_a, j), j);
      lb = src_lookup(arch_at(bus.in_src_b, j), j);
      ren_psrc_a_s[j*LOG_PHYS +: LOG_PHYS] = la[LOG_PHYS:1];
      ren_psrc_b_s[j*LOG_PHYS +: LOG_PHYS] = lb[LOG_PHYS:1];
      ren_rdy_a_s[j] = la[0];
      ren_rdy_b_s[j] = lb[0];
      ren_pdst_s[j*LOG_PHYS +: LOG_PHYS] = new_pdst_s[j];
      if (alloc_s[j]) ren_old_s[j*LOG_PHYS +: LOG_PHYS] = old_lookup(arch_at(bus.in_dst, j), j);
      else            ren_old_s[j*LOG_PHYS +: LOG_PHYS] = '0;
    end
  end

  // Busy set is applied after the writeback clear so a same-cycle realloc stays busy.
  always_comb begin
    map_d       = map_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    psrc_a_d    = psrc_a_q;
    psrc_b_d    = psrc_b_q;
    rdy_a_d     = rdy_a_q;
    rdy_b_d     = rdy_b_q;
    pdst_d      = pdst_q;
    old_d       = old_q;
    if (bus.flush) begin
      for (int i = 0; i < NUM_ARCH; i++) map_d[i] = bus.restore_map[i*LOG_PHYS +: LOG_PHYS];
      busy_d      = '0;
      out_valid_d = '0;
    end else begin
      if (bus.wb_valid) busy_d[bus.wb_preg] = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if ((j < k_s) && alloc_s[j]) begin
          map_d[arch_at(bus.in_dst, j)] = new_pdst_s[j];
          busy_d[new_pdst_s[j]]         = 1'b1;
        end
      end
      if (k_s > 0) begin
        for (int j = 0; j < WIDTH; j++) out_valid_d[j] = (j < k_s);
        psrc_a_d = ren_psrc_a_s;
        psrc_b_d = ren_psrc_b_s;
        rdy_a_d  = ren_rdy_a_s;
        rdy_b_d  = ren_rdy_b_s;
        pdst_d   = ren_pdst_s;
        old_d    = ren_old_s;
      end else if (bus.out_ready) begin
        out_valid_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= LOG_PHYS'(i);
      busy_q      <= '0;
      out_valid_q <= '0;
      psrc_a_q    <= '0;
      psrc_b_q    <= '0;
      rdy_a_q     <= '0;
      rdy_b_q     <= '0;
      pdst_q      <= '0;
      old_q       <= '0;
    end else begin
      map_q       <= map_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      psrc_a_q    <= psrc_a_d;
      psrc_b_q    <= psrc_b_d;
      rdy_a_q     <= rdy_a_d;
      rdy_b_q     <= rdy_b_d;
      pdst_q      <= pdst_d;
      old_q       <= old_d;
    end
  end

  assign bus.in_take      = CW'(k_s);
  assign bus.alloc_count  = CW'(nalloc_s);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_psrc_a   = psrc_a_q;
  assign bus.out_psrc_b   = psrc_b_q;
  assign bus.out_rdy_a    = rdy_a_q;
  assign bus.out_rdy_b    = rdy_b_q;
  assign bus.out_pdst     = pdst_q;
  assign bus.out_old_pdst = old_q;
endmodule

// File: tb/tb_rename_nwide.sv
// Directed-vector bench for rename_nwide (WIDTH=2); each task checks its own scenario inline.
module tb_rename_nwide;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rename_nwide_if #(.WIDTH(2), .NUM_ARCH(32), .LOG_ARCH(5), .LOG_PHYS(6), .CW(2)) bus ();

  rename_nwide #(.WIDTH(2), .NUM_ARCH(32), .LOG_ARCH(5), .NUM_PHYS(64), .LOG_PHYS(6), .CW(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pf(input logic [11:0] v, input int j);
    return v[j*6 +: 6];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid     = 2'b00;
    bus.in_src_a     = 10'd0;
    bus.in_src_b     = 10'd0;
    bus.in_dst       = 10'd0;
    bus.in_reg_write = 2'b00;
    bus.wb_valid     = 1'b0;
    bus.wb_preg      = 6'd0;
    bus.flush        = 1'b0;
  endtask

  task automatic set_slot(input int j, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic w);
    bus.in_valid[j]           = 1'b1;
    bus.in_src_a[j*5 +: 5]    = a;
    bus.in_src_b[j*5 +: 5]    = b;
    bus.in_dst[j*5 +: 5]      = d;
    bus.in_reg_write[j]       = w;
  endtask

  task automatic test_reset();
    set_slot(0, 5'd1, 5'd2, 5'd3, 1'b1);
    #1;
    total++; if (bus.in_take !== 2'd0) begin bad++; $display("FAIL reset_take got=%0d exp=0", bus.in_take); end
    total++; if (bus.alloc_count !== 2'd0) begin bad++; $display("FAIL reset_alloc got=%0d exp=0", bus.alloc_count); end
    step(); step();
    total++; if (bus.out_valid !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", bus.out_valid); end
    total++; if (bus.out_pdst !== 12'd0) begin bad++; $display("FAIL reset_pdst got=%h exp=0", bus.out_pdst); end
    rst = 1'b0;
    clear_in();
  endtask

  task automatic test_basic();
    set_slot(0, 5'd1, 5'd2, 5'd3, 1'b1);
    set_slot(1, 5'd3, 5'd1, 5'd4, 1'b1);
    bus.free_regs = {6'd41, 6'd40};
    #1;
    total++; if (bus.in_take !== 2'd2) begin bad++; $display("FAIL basic_take got=%0d exp=2", bus.in_take); end
    total++; if (bus.alloc_count !== 2'd2) begin bad++; $display("FAIL basic_alloc got=%0d exp=2", bus.alloc_count); end
    step();
    clear_in();
    total++; if (bus.out_valid !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b exp=11", bus.out_valid); end
    total++; if (bus.out_psrc_a !== {6'd40, 6'd1}) begin bad++; $display("FAIL basic_psrc_a got=%h exp=%h", bus.out_psrc_a, {6'd40, 6'd1}); end
    total++; if (bus.out_psrc_b !== {6'd1, 6'd2}) begin bad++; $display("FAIL basic_psrc_b got=%h exp=%h", bus.out_psrc_b, {6'd1, 6'd2}); end
    total++; if (bus.out_rdy_a !== 2'b01) begin bad++; $display("FAIL basic_rdy_a got=%b exp=01", bus.out_rdy_a); end
    total++; if (bus.out_rdy_b !== 2'b11) begin bad++; $display("FAIL basic_rdy_b got=%b exp=11", bus.out_rdy_b); end
    total++; if (bus.out_pdst !== {6'd41, 6'd40}) begin bad++; $display("FAIL basic_pdst got=%h exp=%h", bus.out_pdst, {6'd41, 6'd40}); end
    total++; if (bus.out_old_pdst !== {6'd4, 6'd3}) begin bad++; $display("FAIL basic_old got=%h exp=%h", bus.out_old_pdst, {6'd4, 6'd3}); end
  endtask

  task automatic test_dup_dst();
    set_slot(0, 5'd0, 5'd0, 5'd5, 1'b1);
    set_slot(1, 5'd0, 5'd0, 5'd5, 1'b1);
    bus.free_regs = {6'd51, 6'd50};
    #1;
    total++; if (bus.in_take !== 2'd2) begin bad++; $display("FAIL dup_take got=%0d exp=2", bus.in_take); end
    step();
    clear_in();
    total++; if (bus.out_old_pdst !== {6'd50, 6'd5}) begin bad++; $display("FAIL dup_old got=%h exp=%h", bus.out_old_pdst, {6'd50, 6'd5}); end
    total++; if (bus.out_pdst !== {6'd51, 6'd50}) begin bad++; $display("FAIL dup_pdst got=%h exp=%h", bus.out_pdst, {6'd51, 6'd50}); end
    set_slot(0, 5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    total++; if (bus.in_take !== 2'd1) begin bad++; $display("FAIL dup_read_take got=%0d exp=1", bus.in_take); end
    step();
    total++; if (pf(bus.out_psrc_a, 0) !== 6'd51) begin bad++; $display("FAIL dup_read_psrc got=%0d exp=51", pf(bus.out_psrc_a, 0)); end
    total++; if (bus.out_rdy_a[0] !== 1'b0) begin bad++; $display("FAIL dup_read_rdy got=%b exp=0", bus.out_rdy_a[0]); end
    total++; if (bus.out_rdy_b[0] !== 1'b1 || pf(bus.out_psrc_b, 0) !== 6'd0) begin bad++; $display("FAIL dup_r0 got=%b/%0d exp=1/0", bus.out_rdy_b[0], pf(bus.out_psrc_b, 0)); end
    bus.wb_valid = 1'b1;
    bus.wb_preg  = 6'd51;
    step();
    clear_in();
    total++; if (bus.out_rdy_a[0] !== 1'b1) begin bad++; $display("FAIL dup_wb_rdy got=%b exp=1", bus.out_rdy_a[0]); end
    total++; if (pf(bus.out_psrc_a, 0) !== 6'd51) begin bad++; $display("FAIL dup_wb_psrc got=%0d exp=51", pf(bus.out_psrc_a, 0)); end
  endtask

  task automatic test_free_limit();
    bus.free_count = 7'd1;
    set_slot(0, 5'd0, 5'd0, 5'd6, 1'b1);
    set_slot(1, 5'd0, 5'd0, 5'd7, 1'b1);
    bus.free_regs = {6'd53, 6'd52};
    #1;
    total++; if (bus.in_take !== 2'd1) begin bad++; $display("FAIL free_take got=%0d exp=1", bus.in_take); end
    total++; if (bus.alloc_count !== 2'd1) begin bad++; $display("FAIL free_alloc got=%0d exp=1", bus.alloc_count); end
    step();
    clear_in();
    total++; if (bus.out_valid !== 2'b01) begin bad++; $display("FAIL free_valid got=%b exp=01", bus.out_valid); end
    total++; if (pf(bus.out_pdst, 0) !== 6'd52) begin bad++; $display("FAIL free_pdst got=%0d exp=52", pf(bus.out_pdst, 0)); end
    set_slot(0, 5'd1, 5'd1, 5'd0, 1'b1);
    set_slot(1, 5'd0, 5'd0, 5'd8, 1'b1);
    bus.free_regs = {6'd55, 6'd54};
    #1;
    total++; if (bus.in_take !== 2'd2) begin bad++; $display("FAIL nodst_take got=%0d exp=2", bus.in_take); end
    total++; if (bus.alloc_count !== 2'd1) begin bad++; $display("FAIL nodst_alloc got=%0d exp=1", bus.alloc_count); end
    step();
    clear_in();
    bus.free_count = 7'd10;
    total++; if (bus.out_pdst !== {6'd54, 6'd0}) begin bad++; $display("FAIL nodst_pdst got=%h exp=%h", bus.out_pdst, {6'd54, 6'd0}); end
    total++; if (bus.out_old_pdst !== {6'd8, 6'd0}) begin bad++; $display("FAIL nodst_old got=%h exp=%h", bus.out_old_pdst, {6'd8, 6'd0}); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    set_slot(0, 5'd0, 5'd0, 5'd9, 1'b1);
    set_slot(1, 5'd0, 5'd0, 5'd10, 1'b1);
    bus.free_regs = {6'd57, 6'd56};
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.in_take !== 2'd0) begin bad++; $display("FAIL stall_take c=%0d got=%0d exp=0", c, bus.in_take); end
      step();
      total++; if (bus.out_valid !== 2'b11 || bus.out_pdst !== {6'd54, 6'd0}) begin bad++; $display("FAIL stall_hold c=%0d got=%b/%h exp=11/%h", c, bus.out_valid, bus.out_pdst, {6'd54, 6'd0}); end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_take !== 2'd2) begin bad++; $display("FAIL release_take got=%0d exp=2", bus.in_take); end
    step();
    clear_in();
    total++; if (bus.out_pdst !== {6'd57, 6'd56}) begin bad++; $display("FAIL release_pdst got=%h exp=%h", bus.out_pdst, {6'd57, 6'd56}); end
    total++; if (bus.out_old_pdst !== {6'd10, 6'd9}) begin bad++; $display("FAIL release_old got=%h exp=%h", bus.out_old_pdst, {6'd10, 6'd9}); end
  endtask

  task automatic test_hole_space();
    set_slot(1, 5'd0, 5'd0, 5'd12, 1'b1);
    #1;
    total++; if (bus.in_take !== 2'd0) begin bad++; $display("FAIL hole_take got=%0d exp=0", bus.in_take); end
    set_slot(0, 5'd0, 5'd0, 5'd11, 1'b1);
    bus.free_regs = {6'd59, 6'd58};
    bus.rob_space = 2'd1;
    #1;
    total++; if (bus.in_take !== 2'd1) begin bad++; $display("FAIL rob_take got=%0d exp=1", bus.in_take); end
    total++; if (bus.alloc_count !== 2'd1) begin bad++; $display("FAIL rob_alloc got=%0d exp=1", bus.alloc_count); end
    bus.rob_space = 2'd2;
    bus.iq_space  = 2'd1;
    #1;
    total++; if (bus.in_take !== 2'd1) begin bad++; $display("FAIL iq_take got=%0d exp=1", bus.in_take); end
    step();
    clear_in();
    bus.iq_space = 2'd2;
    total++; if (bus.out_valid !== 2'b01 || pf(bus.out_pdst, 0) !== 6'd58) begin bad++; $display("FAIL space_out got=%b/%0d exp=01/58", bus.out_valid, pf(bus.out_pdst, 0)); end
  endtask

  task automatic test_flush();
    set_slot(0, 5'd0, 5'd0, 5'd7, 1'b1);
    bus.free_regs = {6'd61, 6'd60};
    step();
    clear_in();
    total++; if (pf(bus.out_pdst, 0) !== 6'd60 || pf(bus.out_old_pdst, 0) !== 6'd7) begin bad++; $display("FAIL r7_rename got=%0d/%0d exp=60/7", pf(bus.out_pdst, 0), pf(bus.out_old_pdst, 0)); end
    bus.flush = 1'b1;
    set_slot(0, 5'd7, 5'd0, 5'd13, 1'b1);
    #1;
    total++; if (bus.in_take !== 2'd0 || bus.alloc_count !== 2'd0) begin bad++; $display("FAIL flush_take got=%0d/%0d exp=0/0", bus.in_take, bus.alloc_count); end
    step();
    clear_in();
    total++; if (bus.out_valid !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", bus.out_valid); end
    set_slot(0, 5'd7, 5'd0, 5'd0, 1'b0);
    step();
    clear_in();
    total++; if (pf(bus.out_psrc_a, 0) !== 6'd7 || bus.out_rdy_a[0] !== 1'b1) begin bad++; $display("FAIL flush_r7 got=%0d/%b exp=7/1", pf(bus.out_psrc_a, 0), bus.out_rdy_a[0]); end
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    set_slot(0, 5'd0, 5'd0, 5'd3, 1'b1);
    bus.free_regs = {6'd63, 6'd62};
    step(); step();
    total++; if (bus.out_valid !== 2'b01) begin bad++; $display("FAIL mid_hold got=%b exp=01", bus.out_valid); end
    rst = 1'b1;
    step();
    total++; if (bus.out_valid !== 2'b00 || bus.out_psrc_a !== 12'd0) begin bad++; $display("FAIL mid_reset got=%b/%h exp=00/0", bus.out_valid, bus.out_psrc_a); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    clear_in();
    set_slot(0, 5'd3, 5'd4, 5'd0, 1'b0);
    #1;
    total++; if (bus.in_take !== 2'd1) begin bad++; $display("FAIL post_take got=%0d exp=1", bus.in_take); end
    step();
    clear_in();
    total++; if (bus.out_psrc_a !== {6'd0, 6'd3} && pf(bus.out_psrc_a, 0) !== 6'd3) begin bad++; $display("FAIL post_psrc_a got=%0d exp=3", pf(bus.out_psrc_a, 0)); end
    total++; if (pf(bus.out_psrc_b, 0) !== 6'd4) begin bad++; $display("FAIL post_psrc_b got=%0d exp=4", pf(bus.out_psrc_b, 0)); end
    total++; if (bus.out_rdy_a[0] !== 1'b1 || bus.out_rdy_b[0] !== 1'b1) begin bad++; $display("FAIL post_rdy got=%b%b exp=11", bus.out_rdy_a[0], bus.out_rdy_b[0]); end
  endtask

  initial begin
    clear_in();
    bus.free_count = 7'd10;
    bus.free_regs  = 12'd0;
    bus.rob_space  = 2'd2;
    bus.iq_space   = 2'd2;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 32; i++) bus.restore_map[i*6 +: 6] = 6'(i);
    test_reset();
    test_basic();
    test_dup_dst();
    test_free_limit();
    test_stall();
    test_hole_space();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
